// File: rtl/aip_port_arbiter_pkg.sv
// Shared definitions for the two-port AIP arbiter: op encodings and FSM states.
package aip_port_arbiter_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/aip_port_arbiter_if.sv
// Bundle of requester, AIP core and status signals shared by the arbiter and its environment.
// Handshake: a requester raises reqN_valid with op/conf/wdata/lock held stable until reqN_done
// pulses for one cycle; in the following cycle it must drop valid or present a new request.
interface aip_port_arbiter_if
  import aip_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CONF_W = 5
) ();

  logic              req0_valid;
  logic [1:0]        req0_op;
  logic [CONF_W-1:0] req0_conf;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_lock;
  logic              req0_done;
  logic [DATA_W-1:0] req0_rdata;
  logic              req0_int;
  logic              req0_int_clr;

  logic              req1_valid;
  logic [1:0]        req1_op;
  logic [CONF_W-1:0] req1_conf;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_lock;
  logic              req1_done;
  logic [DATA_W-1:0] req1_rdata;
  logic              req1_int;
  logic              req1_int_clr;

  logic [CONF_W-1:0] aip_conf;
  logic              aip_read;
  logic              aip_write;
  logic              aip_start;
  logic [DATA_W-1:0] aip_data_in;
  logic [DATA_W-1:0] aip_data_out;
  logic              aip_int;

  logic              core_busy;
  logic              owner;
  state_e            dbg_state;

  modport slave (
    input  req0_valid, req0_op, req0_conf, req0_wdata, req0_lock, req0_int_clr,
    input  req1_valid, req1_op, req1_conf, req1_wdata, req1_lock, req1_int_clr,
    output req0_done, req0_rdata, req0_int, req1_done, req1_rdata, req1_int,
    output aip_conf, aip_read, aip_write, aip_start, aip_data_in,
    input  aip_data_out, aip_int,
    output core_busy, owner, dbg_state
  );

  modport master (
    output req0_valid, req0_op, req0_conf, req0_wdata, req0_lock, req0_int_clr,
    output req1_valid, req1_op, req1_conf, req1_wdata, req1_lock, req1_int_clr,
    input  req0_done, req0_rdata, req0_int, req1_done, req1_rdata, req1_int,
    input  aip_conf, aip_read, aip_write, aip_start, aip_data_in,
    output aip_data_out, aip_int,
    input  core_busy, owner, dbg_state
  );

endinterface

// File: rtl/aip_rr_arb2.sv
// Two-input round-robin arbiter; a requester finishing with lock set keeps exclusive access.
module aip_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  input  logic       release_i,
  input  logic       release_lock_i,
  input  logic       release_idx_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic       prio_q;
  logic       lock_q;
  logic       lock_own_q;
  logic [1:0] eff;

  always_comb begin
    eff = req_i & (lock_q ? (lock_own_q ? 2'b10 : 2'b01) : 2'b11);
    gnt_valid_o = |eff;
    gnt_idx_o   = (eff == 2'b11) ? prio_q : eff[1];
  end

  // Tie priority goes to whichever requester was not granted last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_own_q <= 1'b0;
    end else begin
      if (accept_i) prio_q <= ~gnt_idx_o;
      if (release_i) begin
        lock_q     <= release_lock_i;
        lock_own_q <= release_idx_i;
      end
    end
  end

endmodule

// File: rtl/aip_port_arbiter.sv
// Shares one AIP core between the CPU bridge (0) and the NIC (1); tracks core ownership and done flags.
module aip_port_arbiter
  import aip_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CONF_W = 5,
  parameter int RD_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  aip_port_arbiter_if.slave bus
);

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_e            state_q;
  logic              gnt_q;
  logic [1:0]        op_q;
  logic              lock_q;
  logic [1:0]        cnt_q;
  logic [CONF_W-1:0] conf_q;
  logic              rd_q, wr_q, st_q;
  logic [DATA_W-1:0] din_q;
  logic [1:0]        done_q;
  logic [1:0]        int_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              busy_q, owner_q, aip_int_prev_q;

  logic [1:0]        elig;
  logic              gnt_valid, gnt_idx, accept, int_rise;
  logic [1:0]        int_set, int_clr;
  logic [1:0]        sel_op;
  logic [CONF_W-1:0] sel_conf;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_lock;

  assign elig[0] = bus.req0_valid & ~((bus.req0_op == OP_START) & busy_q);
  assign elig[1] = bus.req1_valid & ~((bus.req1_op == OP_START) & busy_q);

  assign sel_op    = gnt_idx ? bus.req1_op    : bus.req0_op;
  assign sel_conf  = gnt_idx ? bus.req1_conf  : bus.req0_conf;
  assign sel_wdata = gnt_idx ? bus.req1_wdata : bus.req0_wdata;
  assign sel_lock  = gnt_idx ? bus.req1_lock  : bus.req0_lock;

  assign accept   = (state_q == ST_IDLE) & gnt_valid;
  assign int_rise = bus.aip_int & ~aip_int_prev_q;
  assign int_set  = (busy_q & int_rise) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign int_clr  = {bus.req1_int_clr, bus.req0_int_clr};

  aip_rr_arb2 u_arb (
    .clk            (clk),
    .rst            (rst),
    .req_i          (elig),
    .accept_i       (accept),
    .release_i      (state_q == ST_DONE),
    .release_lock_i (lock_q),
    .release_idx_i  (gnt_q),
    .gnt_valid_o    (gnt_valid),
    .gnt_idx_o      (gnt_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      gnt_q          <= 1'b0;
      op_q           <= OP_READ;
      lock_q         <= 1'b0;
      cnt_q          <= 2'd0;
      conf_q         <= '0;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      st_q           <= 1'b0;
      din_q          <= '0;
      done_q         <= 2'b00;
      int_q          <= 2'b00;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
      busy_q         <= 1'b0;
      owner_q        <= 1'b0;
      aip_int_prev_q <= 1'b0;
    end else begin
      aip_int_prev_q <= bus.aip_int;
      // A set in the same cycle as a clear leaves the flag high.
      int_q <= int_set | (int_q & ~int_clr);
      if (int_set != 2'b00) busy_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            gnt_q   <= gnt_idx;
            op_q    <= sel_op;
            lock_q  <= sel_lock;
            conf_q  <= sel_conf;
            state_q <= ST_ISSUE;
            case (sel_op)
              OP_READ:  rd_q <= 1'b1;
              OP_WRITE: begin
                wr_q  <= 1'b1;
                din_q <= sel_wdata;
              end
              OP_START: begin
                st_q    <= 1'b1;
                busy_q  <= 1'b1;
                owner_q <= gnt_idx;
              end
              default: ;
            endcase
          end
        end
        ST_ISSUE: begin
          rd_q <= 1'b0;
          wr_q <= 1'b0;
          st_q <= 1'b0;
          if (op_q == OP_READ) begin
            cnt_q   <= WAIT_INIT;
            state_q <= ST_WAIT_RD;
          end else begin
            done_q[gnt_q] <= 1'b1;
            state_q       <= ST_DONE;
          end
        end
        ST_WAIT_RD: begin
          if (cnt_q == 2'd0) begin
            if (gnt_q) rdata1_q <= bus.aip_data_out;
            else       rdata0_q <= bus.aip_data_out;
            done_q[gnt_q] <= 1'b1;
            state_q       <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ST_DONE: begin
          done_q  <= 2'b00;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.aip_conf    = conf_q;
  assign bus.aip_read    = rd_q;
  assign bus.aip_write   = wr_q;
  assign bus.aip_start   = st_q;
  assign bus.aip_data_in = din_q;
  assign bus.req0_done   = done_q[0];
  assign bus.req1_done   = done_q[1];
  assign bus.req0_rdata  = rdata0_q;
  assign bus.req1_rdata  = rdata1_q;
  assign bus.req0_int    = int_q[0];
  assign bus.req1_int    = int_q[1];
  assign bus.core_busy   = busy_q;
  assign bus.owner       = owner_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_aip_port_arbiter.sv
// Directed bench for aip_port_arbiter with RD_LAT=2 and a small AIP core read model.
module tb_aip_port_arbiter;
  import aip_port_arbiter_pkg::*;

  localparam int DATA_W = 32;
  localparam int CONF_W = 5;
  localparam int RD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aip_port_arbiter_if #(.DATA_W(DATA_W), .CONF_W(CONF_W)) bus ();

  aip_port_arbiter #(.DATA_W(DATA_W), .CONF_W(CONF_W), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- core model: read data valid RD_LAT cycles after the strobe ----------------
  logic [31:0] core_data [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [1:0]  rd_pipe;
  int          rd_issued = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) rd_pipe <= 2'b00;
    else     rd_pipe <= {rd_pipe[0], bus.aip_read};
  end
  always @(posedge clk) if (bus.aip_read) rd_issued <= rd_issued + 1;
  assign bus.aip_data_out = rd_pipe[RD_LAT-1] ? core_data[2'(rd_issued - 1)] : 32'hBAD0BAD0;

  // ---------------- monitor ----------------
  int          wr_cnt = 0, rd_cnt = 0, st_cnt = 0;
  int          done_cnt [2] = '{0, 0};
  logic [31:0] wr_data = '0;
  logic [4:0]  wr_conf = '0;

  always @(negedge clk) begin
    if (bus.aip_write) begin
      wr_cnt++;
      wr_conf = bus.aip_conf;
      wr_data = bus.aip_data_in;
    end
    if (bus.aip_read)  rd_cnt++;
    if (bus.aip_start) st_cnt++;
    if (bus.req0_done) done_cnt[0]++;
    if (bus.req1_done) done_cnt[1]++;
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input logic v, input logic [1:0] op,
                       input logic [4:0] conf, input logic [31:0] wd, input logic lk);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_conf = conf;
      bus.req0_wdata = wd; bus.req0_lock = lk;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_conf = conf;
      bus.req1_wdata = wd; bus.req1_lock = lk;
    end
  endtask

  // Latency counts the cycle valid was presented as cycle 1.
  task automatic wait_done(input int n, input int max_cyc, output int lat);
    lat = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if ((n == 0 && bus.req0_done) || (n == 1 && bus.req1_done)) begin
        lat = c;
        break;
      end
    end
    check($sformatf("done%0d_seen", n), 32'(lat != 0), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 1'b0, OP_READ, 5'h0, 32'h0, 1'b0);
    drive(1, 1'b0, OP_READ, 5'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_state"},   32'(bus.dbg_state), 32'(ST_IDLE));
    check({pfx, "_strobes"}, {29'd0, bus.aip_read, bus.aip_write, bus.aip_start}, 32'd0);
    check({pfx, "_conf"},    32'(bus.aip_conf), 32'd0);
    check({pfx, "_din"},     bus.aip_data_in, 32'd0);
    check({pfx, "_done"},    {30'd0, bus.req1_done, bus.req0_done}, 32'd0);
    check({pfx, "_rdata0"},  bus.req0_rdata, 32'd0);
    check({pfx, "_rdata1"},  bus.req1_rdata, 32'd0);
    check({pfx, "_int"},     {30'd0, bus.req1_int, bus.req0_int}, 32'd0);
    check({pfx, "_busy"},    32'(bus.core_busy), 32'd0);
    check({pfx, "_owner"},   32'(bus.owner), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int snap_a, snap_b, snap_c;
    bus.aip_int = 1'b0;
    bus.req0_int_clr = 1'b0;
    bus.req1_int_clr = 1'b0;
    rst = 1'b1;
    drive(0, 1'b0, OP_READ, 5'h0, 32'h0, 1'b0);
    drive(1, 1'b0, OP_READ, 5'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst = 1'b0;

    // Single write from the CPU bridge.
    drive(0, 1'b1, OP_WRITE, 5'h02, 32'hDEADBEEF, 1'b0);
    wait_done(0, 10, lat);
    check("wr_latency", 32'(lat), 32'd3);
    next_cycle();
    drive(0, 1'b0, OP_WRITE, 5'h02, 32'hDEADBEEF, 1'b0);
    check("wr_strobe_cnt", 32'(wr_cnt), 32'd1);
    check("wr_conf", 32'(wr_conf), 32'h02);
    check("wr_data", wr_data, 32'hDEADBEEF);
    check("wr_no_rd_st", 32'(rd_cnt + st_cnt), 32'd0);

    // Simultaneous reads after reset: req0, then req1 wins the re-tie, then req0.
    do_reset();
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h33);
    drive(0, 1'b1, OP_READ, 5'h01, 32'h0, 1'b0);
    drive(1, 1'b1, OP_READ, 5'h03, 32'h0, 1'b0);
    wait_done(0, 12, lat);
    check("rd0_latency", 32'(lat), 32'(3 + RD_LAT));
    check("rd0_data", bus.req0_rdata, exp_q.pop_front());
    next_cycle();
    drive(0, 1'b1, OP_READ, 5'h04, 32'h0, 1'b0);
    wait_done(1, 12, lat);
    check("rr_tie_to_req1_lat", 32'(lat), 32'(3 + RD_LAT));
    check("rd1_data", bus.req1_rdata, exp_q.pop_front());
    check("rd0_data_held", bus.req0_rdata, 32'h11);
    next_cycle();
    drive(1, 1'b0, OP_READ, 5'h0, 32'h0, 1'b0);
    wait_done(0, 12, lat);
    check("rd0b_latency", 32'(lat), 32'(3 + RD_LAT));
    check("rd0b_data", bus.req0_rdata, exp_q.pop_front());
    next_cycle();

    // Lock: req0 holds the core for three writes while req1 waits.
    drive(0, 1'b1, OP_WRITE, 5'h08, 32'hA0, 1'b1);
    next_cycle();
    drive(1, 1'b1, OP_WRITE, 5'h09, 32'hB0, 1'b0);
    snap_a = done_cnt[1];
    wait_done(0, 6, lat);
    check("lock_w1_data", wr_data, 32'hA0);
    next_cycle();
    drive(0, 1'b1, OP_WRITE, 5'h08, 32'hC0, 1'b1);
    wait_done(0, 6, lat);
    check("lock_w2_lat", 32'(lat), 32'd3);
    check("lock_w2_data", wr_data, 32'hC0);
    next_cycle();
    drive(0, 1'b1, OP_WRITE, 5'h08, 32'hD0, 1'b0);
    wait_done(0, 6, lat);
    check("lock_w3_lat", 32'(lat), 32'd3);
    check("lock_w3_data", wr_data, 32'hD0);
    next_cycle();
    drive(0, 1'b0, OP_WRITE, 5'h0, 32'h0, 1'b0);
    check("lock_req1_held_off", 32'(done_cnt[1] - snap_a), 32'd0);
    wait_done(1, 6, lat);
    check("unlock_req1_lat", 32'(lat), 32'd3);
    check("unlock_req1_data", wr_data, 32'hB0);
    check("unlock_req1_conf", 32'(wr_conf), 32'h09);
    next_cycle();
    drive(1, 1'b0, OP_WRITE, 5'h0, 32'h0, 1'b0);

    // Start from req1, then req0 start stalls while the core is busy.
    drive(1, 1'b1, OP_START, 5'h01, 32'h0, 1'b0);
    wait_done(1, 6, lat);
    check("st1_lat", 32'(lat), 32'd3);
    check("st1_busy", 32'(bus.core_busy), 32'd1);
    check("st1_owner", 32'(bus.owner), 32'd1);
    next_cycle();
    drive(1, 1'b0, OP_READ, 5'h0, 32'h0, 1'b0);
    drive(0, 1'b1, OP_START, 5'h02, 32'h0, 1'b0);
    snap_a = st_cnt;
    snap_b = done_cnt[0];
    repeat (6) next_cycle();
    check("st0_stalled_strobe", 32'(st_cnt - snap_a), 32'd0);
    check("st0_stalled_done", 32'(done_cnt[0] - snap_b), 32'd0);
    check("st0_stalled_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    // Reads stay legal while busy.
    exp_q.push_back(32'h44);
    drive(1, 1'b1, OP_READ, 5'h03, 32'h0, 1'b0);
    wait_done(1, 12, lat);
    check("busy_rd1_lat", 32'(lat), 32'(3 + RD_LAT));
    check("busy_rd1_data", bus.req1_rdata, exp_q.pop_front());
    next_cycle();
    drive(1, 1'b0, OP_READ, 5'h0, 32'h0, 1'b0);
    bus.aip_int = 1'b1;
    next_cycle();
    bus.aip_int = 1'b0;
    check("int1_set", 32'(bus.req1_int), 32'd1);
    check("int_busy_clr", 32'(bus.core_busy), 32'd0);
    wait_done(0, 8, lat);
    check("st0_owner", 32'(bus.owner), 32'd0);
    check("st0_busy", 32'(bus.core_busy), 32'd1);
    check("int0_clear", 32'(bus.req0_int), 32'd0);
    next_cycle();
    drive(0, 1'b0, OP_READ, 5'h0, 32'h0, 1'b0);
    check("st0_issued", 32'(st_cnt - snap_a), 32'd1);
    bus.req1_int_clr = 1'b1;
    next_cycle();
    bus.req1_int_clr = 1'b0;
    check("int1_cleared", 32'(bus.req1_int), 32'd0);

    // Coincident set and clear, then clear alone, then int ignored while idle.
    bus.aip_int = 1'b1;
    bus.req0_int_clr = 1'b1;
    next_cycle();
    bus.aip_int = 1'b0;
    bus.req0_int_clr = 1'b0;
    check("int0_set_wins", 32'(bus.req0_int), 32'd1);
    check("int0_busy_clr", 32'(bus.core_busy), 32'd0);
    bus.req0_int_clr = 1'b1;
    next_cycle();
    bus.req0_int_clr = 1'b0;
    check("int0_cleared", 32'(bus.req0_int), 32'd0);
    bus.aip_int = 1'b1;
    repeat (2) next_cycle();
    bus.aip_int = 1'b0;
    next_cycle();
    check("idle_int_ignored", {30'd0, bus.req1_int, bus.req0_int}, 32'd0);
    check("idle_int_busy", 32'(bus.core_busy), 32'd0);

    // Reserved op completes with no strobe.
    snap_a = rd_cnt; snap_b = wr_cnt; snap_c = st_cnt;
    drive(0, 1'b1, OP_RSVD, 5'h1F, 32'h0, 1'b0);
    wait_done(0, 6, lat);
    check("rsvd_lat", 32'(lat), 32'd3);
    next_cycle();
    drive(0, 1'b0, OP_READ, 5'h0, 32'h0, 1'b0);
    check("rsvd_no_strobe", 32'((rd_cnt - snap_a) + (wr_cnt - snap_b) + (st_cnt - snap_c)), 32'd0);

    // Reset while waiting for read data aborts the transaction.
    drive(0, 1'b1, OP_READ, 5'h04, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_in_wait_rd", 32'(bus.dbg_state), 32'(ST_WAIT_RD));
    rst = 1'b1;
    #1;
    check_reset_values("abort");
    drive(0, 1'b0, OP_READ, 5'h0, 32'h0, 1'b0);
    snap_a = done_cnt[0];
    snap_b = rd_cnt;
    repeat (3) next_cycle();
    check("abort_no_done", 32'(done_cnt[0] - snap_a), 32'd0);
    check("abort_no_strobe", 32'(rd_cnt - snap_b), 32'd0);
    rst = 1'b0;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
